// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA sync generator, double-buffered packed-pixel framebuffer,
// programmable palette and aligned RGB/sync output registers.
// Scanout reads the front buffer. The producer writes into the back buffer,
// and a requested flip takes effect at the start of vertical blanking.
// Optional feature macro: VGA_FB_TEST_PATTERN_EN adds input tp_sel, which
// selects an 8x8 checkerboard instead of the framebuffer contents.
module vga_fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BPP      = 1,
  parameter int WORD_W   = 32,
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE * BPP / WORD_W,
  localparam int AW       = $clog2(FB_WORDS)
) (
  input  logic              CLK_25,
  input  logic              Reset,
  input  logic [2:0]        chan_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_idx,
  input  logic [11:0]       pal_data,
  output logic [3:0]        RED,
  output logic [3:0]        GREEN,
  output logic [3:0]        BLUE,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start
`ifdef VGA_FB_TEST_PATTERN_EN
  ,
  input  logic              tp_sel
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int PPW     = WORD_W / BPP;          // pixels per memory word
  localparam int WPL     = H_ACTIVE / PPW;        // words per visible line
  localparam int KW      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int DEPTH   = 2 ** (AW + 1);         // buffer select is the address MSB
  localparam int NPAL    = 2 ** BPP;

  typedef enum logic {IDLE, PENDING} swapState_t;

  swapState_t state, stateNext;
  logic       front, swapFire, swapAckQ;

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic          active0, hsync0, vsync0, fstart0;
  logic [AW-1:0] wordAddr0;
  logic [KW-1:0] k0;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [11:0]       palette [NPAL];

  logic [WORD_W-1:0] ramQ_p1;
  logic [KW-1:0]     k_p1;
  logic              act_p1, hs_p1, vs_p1, fs_p1;
  logic [BPP-1:0]    pixIdx_p1;
  logic [11:0]       color_p2;
  logic              act_p2, hs_p2, vs_p2, fs_p2;
`ifdef VGA_FB_TEST_PATTERN_EN
  logic              tpSel_p1, tpBit_p1;
`endif

  // Pixel/line counters: x wraps at H_TOTAL and advances y on wrap
  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) begin
      x <= '0;
      y <= '0;
    end else if (x == XW'(H_TOTAL - 1)) begin
      x <= '0;
      y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  // Q0 decode: active region, sync windows, frame origin and scanout address
  always_comb begin
    active0   = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
    hsync0    = !((x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync0    = !((y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC)));
    fstart0   = (x == '0) && (y == '0);
    wordAddr0 = AW'(int'(y) * WPL + int'(x) / PPW);
    k0        = KW'(int'(x) % PPW);
  end

  // Swap FSM state, front-buffer select and the registered acknowledge
  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      front    <= 1'b0;
      swapAckQ <= 1'b0;
    end else begin
      state    <= stateNext;
      front    <= front ^ swapFire;
      swapAckQ <= swapFire;
    end
  end

  // Swap FSM next state: a pending flip fires on the first blank line
  always_comb begin
    stateNext = state;
    swapFire  = 1'b0;
    case (state)
      IDLE:    if (swap_req) stateNext = PENDING;
      PENDING: begin
        if ((x == '0) && (y == YW'(V_ACTIVE))) begin
          swapFire  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign wr_ready = (state == IDLE);
  assign swap_ack = swapAckQ;

  // Producer write into the back buffer; out-of-range addresses are dropped
  always_ff @(posedge CLK_25) begin
    if (wr_valid && wr_ready && (int'(wr_addr) < FB_WORDS))
      mem[{!front, wr_addr}] <= wr_data;
  end

  // Q1 data: registered front-buffer read plus the pixel slot within the word
  always_ff @(posedge CLK_25) begin
    ramQ_p1 <= mem[{front, wordAddr0}];
    k_p1    <= k0;
`ifdef VGA_FB_TEST_PATTERN_EN
    tpSel_p1 <= tp_sel;
    tpBit_p1 <= x[3] ^ y[3];
`endif
  end

  // Q1 bit-select: choose the palette index from the word or the checkerboard
  always_comb begin
    pixIdx_p1 = ramQ_p1[k_p1 * BPP +: BPP];
`ifdef VGA_FB_TEST_PATTERN_EN
    if (tpSel_p1) pixIdx_p1 = {BPP{tpBit_p1}};
`endif
  end

  // Palette registers: entry 0 is black, the rest white out of reset
  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NPAL; i++)
        palette[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else if (pal_we) begin
      palette[pal_idx] <= pal_data;
    end
  end

  // Q2 data: palette lookup
  always_ff @(posedge CLK_25) begin
    color_p2 <= palette[pixIdx_p1];
  end

  // Control pipeline Q1/Q2: active, syncs and frame origin follow the pixel data
  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) begin
      act_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      fs_p1  <= 1'b0;
      act_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      fs_p2  <= 1'b0;
    end else begin
      act_p1 <= active0;
      hs_p1  <= hsync0;
      vs_p1  <= vsync0;
      fs_p1  <= fstart0;
      act_p2 <= act_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      fs_p2  <= fs_p1;
    end
  end

  // Q3 output registers: blanking and channel enables applied before the pins
  always_ff @(posedge CLK_25 or negedge Reset) begin
    if (!Reset) begin
      RED         <= 4'h0;
      GREEN       <= 4'h0;
      BLUE        <= 4'h0;
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      RED         <= (act_p2 && chan_en[0]) ? color_p2[11:8] : 4'h0;
      GREEN       <= (act_p2 && chan_en[1]) ? color_p2[7:4]  : 4'h0;
      BLUE        <= (act_p2 && chan_en[2]) ? color_p2[3:0]  : 4'h0;
      h_sync      <= hs_p2;
      v_sync      <= vs_p2;
      frame_start <= fs_p2;
    end
  end

endmodule
